// File: rtl/add_sub_operand_sequencer.sv
// add_sub_operand_sequencer: loads A, B, opcode from a stream, drives a 4-bit add/sub stage, returns {c,s}
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   i_in_valid/o_in_ready      input word handshake; i_in_data = A, then B, then opcode (bit0 = t)
//   o_op_a/o_op_b/o_op_t       registered operands to the add/sub stage (t: 1 = add, 0 = subtract)
//   i_res_c/i_res_s            combinational {c,s} return from the add/sub stage
//   o_out_valid/i_out_ready    result handshake; o_out_data = {c,s}, o_out_op = t used
//   o_busy                     high whenever not waiting for operand A
//   o_timeout_err              one-cycle abort pulse (tied 0 unless ADD_SUB_TIMEOUT_EN is defined)
// Optional feature macro: ADD_SUB_TIMEOUT_EN enables the mid-load idle timeout.
module add_sub_operand_sequencer #(
  parameter int WIDTH          = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_data,
  output logic [WIDTH-1:0] o_op_a,
  output logic [WIDTH-1:0] o_op_b,
  output logic             o_op_t,
  input  logic             i_res_c,
  input  logic [WIDTH-1:0] i_res_s,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH:0]   o_out_data,
  output logic             o_out_op,
  output logic             o_busy,
  output logic             o_timeout_err
);
  if (WIDTH < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("add_sub_operand_sequencer: WIDTH must be >= 2 and TIMEOUT_CYCLES >= 1");
  end
  typedef enum logic [2:0] {S_A, S_B, S_T, S_ISSUE, S_OUT} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_op_a, r_op_b;
  logic             r_op_t, r_out_valid, r_out_op;
  logic [WIDTH:0]   r_out_data;
  logic             w_accept, w_timeout, w_loading;
  assign w_loading  = r_state == S_A || r_state == S_B || r_state == S_T;
  // A word offered on the timeout cycle is refused so the abort is clean.
  assign o_in_ready = w_loading && !w_timeout;
  assign w_accept   = i_in_valid && o_in_ready;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_A:     w_next = w_accept ? S_B : S_A;
      S_B:     w_next = w_timeout ? S_A : (w_accept ? S_T : S_B);
      S_T:     w_next = w_timeout ? S_A : (w_accept ? S_ISSUE : S_T);
      S_ISSUE: w_next = S_OUT;
      S_OUT:   w_next = i_out_ready ? S_A : S_OUT;
      default: w_next = S_A;
    endcase
  end
  // Operands only move on their own load edge, so the adder sees stable inputs in S_ISSUE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_A;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_op_t      <= 1'b0;
      r_out_data  <= '0;
      r_out_op    <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept && r_state == S_A) r_op_a <= i_in_data;
      if (w_accept && r_state == S_B) r_op_b <= i_in_data;
      if (w_accept && r_state == S_T) r_op_t <= i_in_data[0];
      if (r_state == S_ISSUE) begin
        r_out_data  <= {i_res_c, i_res_s};
        r_out_op    <= r_op_t;
        r_out_valid <= 1'b1;
      end else if (r_state == S_OUT && i_out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end
`ifdef ADD_SUB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  assign w_timeout = (r_state == S_B || r_state == S_T) && r_cnt == CW'(TIMEOUT_CYCLES);
  always_ff @(posedge clk) begin
    if (!rst_n) r_cnt <= '0;
    else if (w_accept || w_next == S_A) r_cnt <= '0;
    else if ((r_state == S_B || r_state == S_T) && !i_in_valid) r_cnt <= r_cnt + 1'b1;
  end
`else
  assign w_timeout = 1'b0;
`endif
  assign o_op_a        = r_op_a;
  assign o_op_b        = r_op_b;
  assign o_op_t        = r_op_t;
  assign o_out_valid   = r_out_valid;
  assign o_out_data    = r_out_data;
  assign o_out_op      = r_out_op;
  assign o_busy        = r_state != S_A;
  assign o_timeout_err = w_timeout;
endmodule

// File: tb/tb_add_sub_operand_sequencer.sv
// tb_add_sub_operand_sequencer: scoreboard bench with an add/sub stage model for add_sub_operand_sequencer
module tb_add_sub_operand_sequencer;
  localparam int W  = 4;
  localparam int TO = 4;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_in_valid = 1'b0;
  logic         o_in_ready;
  logic [W-1:0] i_in_data = '0;
  logic [W-1:0] o_op_a, o_op_b;
  logic         o_op_t;
  logic         i_res_c;
  logic [W-1:0] i_res_s;
  logic         o_out_valid;
  logic         i_out_ready = 1'b1;
  logic [W:0]   o_out_data;
  logic         o_out_op, o_busy, o_timeout_err;
  typedef struct {logic [W-1:0] a, b, w; logic [W:0] d; logic o;} vec_t;
  typedef struct {logic [W:0] d; logic o;} exp_t;
  exp_t sb[$];
  vec_t vt[9];
  int   n_chk = 0;
  int   n_fail = 0;
  logic         prev_hold = 1'b0;
  logic [W:0]   prev_data = '0;
  add_sub_operand_sequencer #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data),
    .o_op_a(o_op_a), .o_op_b(o_op_b), .o_op_t(o_op_t),
    .i_res_c(i_res_c), .i_res_s(i_res_s),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_out_data(o_out_data), .o_out_op(o_out_op),
    .o_busy(o_busy), .o_timeout_err(o_timeout_err)
  );
  always #5 clk = ~clk;
  // Neighbouring combinational add/sub stage.
  always_comb begin
    logic [W:0] r;
    r = o_op_t ? {1'b0, o_op_a} + {1'b0, o_op_b} : {1'b0, o_op_a} - {1'b0, o_op_b};
    {i_res_c, i_res_s} = r;
  end
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [W-1:0] w);
    int n;
    n = 0;
    i_in_valid = 1'b1;
    i_in_data  = w;
    while (!o_in_ready && n < 64) begin
      tick();
      n++;
    end
    if (n >= 64) chk("in_ready_wait", 0, 1);
    tick();
    i_in_valid = 1'b0;
  endtask
  task automatic run_op(input logic [W-1:0] a, b, w, input logic [W:0] d, input logic o);
    send(a);
    send(b);
    sb.push_back('{d: d, o: o});
    send(w);
  endtask
  // Output side: pop on every handshake, and require held outputs while stalled.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", o_out_valid, 1);
        chk("hold_data", o_out_data, prev_data);
      end
      if (o_out_valid && i_out_ready) begin
        if (sb.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_data", o_out_data, e.d);
          chk("out_op", o_out_op, e.o);
        end
      end
      prev_hold = o_out_valid && !i_out_ready;
      prev_data = o_out_data;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    vt[0] = '{a: 4'd9,  b: 4'd8,  w: 4'b0001, d: 5'b1_0001, o: 1'b1};
    vt[1] = '{a: 4'd3,  b: 4'd5,  w: 4'b0000, d: 5'b1_1110, o: 1'b0};
    vt[2] = '{a: 4'd7,  b: 4'd2,  w: 4'b0000, d: 5'b0_0101, o: 1'b0};
    vt[3] = '{a: 4'd15, b: 4'd15, w: 4'b0001, d: 5'b1_1110, o: 1'b1};
    vt[4] = '{a: 4'd0,  b: 4'd1,  w: 4'b0000, d: 5'b1_1111, o: 1'b0};
    vt[5] = '{a: 4'd0,  b: 4'd0,  w: 4'b0000, d: 5'b0_0000, o: 1'b0};
    vt[6] = '{a: 4'd15, b: 4'd0,  w: 4'b0001, d: 5'b0_1111, o: 1'b1};
    vt[7] = '{a: 4'd6,  b: 4'd1,  w: 4'b1110, d: 5'b0_0101, o: 1'b0};
    vt[8] = '{a: 4'd2,  b: 4'd3,  w: 4'b0011, d: 5'b0_0101, o: 1'b1};
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_out_valid", o_out_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_in_ready", o_in_ready, 1);
    chk("rst_timeout", o_timeout_err, 0);
    chk("rst_op_a", o_op_a, 0);
    chk("rst_out_data", o_out_data, 0);
    // add with exact latency
    run_op(4'd9, 4'd8, 4'd1, 5'b1_0001, 1'b1);
    chk("t1_valid_k", o_out_valid, 0);
    chk("t1_busy", o_busy, 1);
    chk("t1_in_ready_issue", o_in_ready, 0);
    tick();
    chk("t1_valid_k1", o_out_valid, 1);
    chk("t1_data", o_out_data, 5'b1_0001);
    tick();
    chk("t1_valid_drop", o_out_valid, 0);
    chk("t1_idle", o_busy, 0);
    // subtract with borrow, then a second subtract in order
    run_op(4'd3, 4'd5, 4'd0, 5'b1_1110, 1'b0);
    run_op(4'd7, 4'd2, 4'd0, 5'b0_0101, 1'b0);
    // table, back-to-back
    for (int i = 0; i < 9; i++) run_op(vt[i].a, vt[i].b, vt[i].w, vt[i].d, vt[i].o);
    tick();
    tick();
    chk("table_drained", sb.size(), 0);
    // backpressure
    i_out_ready = 1'b0;
    run_op(4'd4, 4'd4, 4'd1, 5'b0_1000, 1'b1);
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("bp_valid", o_out_valid, 1);
      chk("bp_data", o_out_data, 5'b0_1000);
      chk("bp_in_ready", o_in_ready, 0);
      tick();
    end
    i_out_ready = 1'b1;
    tick();
    chk("bp_release", o_out_valid, 0);
    chk("bp_in_ready_back", o_in_ready, 1);
    chk("bp_drained", sb.size(), 0);
    // reset in the middle of a load
    send(4'd6);
    send(4'd2);
    chk("mid_busy", o_busy, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mr_op_a", o_op_a, 0);
    chk("mr_op_b", o_op_b, 0);
    chk("mr_op_t", o_op_t, 0);
    chk("mr_out_valid", o_out_valid, 0);
    chk("mr_out_data", o_out_data, 0);
    chk("mr_out_op", o_out_op, 0);
    chk("mr_busy", o_busy, 0);
    run_op(4'd1, 4'd1, 4'd1, 5'b0_0010, 1'b1);
    tick();
    tick();
`ifdef ADD_SUB_TIMEOUT_EN
    send(4'd5);
    for (int i = 1; i <= TO; i++) begin
      tick();
      chk("to_pulse", o_timeout_err, i == TO);
    end
    chk("to_in_ready", o_in_ready, 0);
    i_in_valid = 1'b1;
    i_in_data  = 4'hA;
    tick();
    i_in_valid = 1'b0;
    chk("to_busy", o_busy, 0);
    chk("to_pulse_end", o_timeout_err, 0);
    chk("to_no_result", o_out_valid, 0);
    run_op(4'd2, 4'd3, 4'd1, 5'b0_0101, 1'b1);
    tick();
    tick();
`endif
    chk("final_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
